// File: rtl/run_sequencer_if.sv
// run_sequencer_if: run-control bundle between the sequencer and the blocks it manages
// Signals:
//   start       - request to begin or restart a session (level)
//   halt        - downstream halt indication, honoured only while running
//   sys_reset   - per-channel active-high downstream resets
//   running     - high while the session is in its run phase
//   done        - session finished
//   timeout     - session ended by the run-cycle limit
//   cycle_count - run cycles elapsed in the current session
// master: the sequencer side; slave: the controlling/observing side.
interface run_sequencer_if #(
    parameter int N_RST = 2,
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt;
    logic [N_RST-1:0] sys_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    modport master (
        input  start, halt,
        output sys_reset, running, done, timeout, cycle_count
    );
    modport slave (
        output start, halt,
        input  sys_reset, running, done, timeout, cycle_count
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: reset-and-run session controller with staggered reset release
// Ports:
//   clk   - system clock, all state updates on its rising edge
//   reset - synchronous active-high reset, returns everything to IDLE
//   bus   - run_sequencer_if.master: start/halt in; sys_reset, running,
//           done, timeout, cycle_count out (all outputs registered)
module run_sequencer #(
    parameter int N_RST       = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int MAX_CYCLES  = 500,
    parameter int CNT_W       = 32,
    parameter int AUTO_START  = 1
) (
    input logic             clk,
    input logic             reset,
    run_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, HOLD, RELEASE, RUN, DONE} state_t;
    // Edge offset, counted from the end of HOLD, at which the last channel frees
    localparam int LAST = (N_RST - 1) * STAGGER;
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CYCLES);
    state_t           r_state;
    logic [31:0]      r_cnt;
    logic [N_RST-1:0] r_sys_reset;
    logic             r_running;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cycle_count;
    logic [N_RST-1:0] w_keep;
    // A channel stays in reset until the elapsed release time reaches i*STAGGER
    always_comb begin
        w_keep = '0;
        for (int i = 0; i < N_RST; i++)
            w_keep[i] = 32'(i * STAGGER) > (r_cnt + 32'd1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sys_reset   <= '1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (AUTO_START != 0 || bus.start) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (r_cnt == 32'(HOLD_CYCLES - 1)) begin
                        r_cnt <= '0;
                        if (LAST == 0) begin
                            r_sys_reset   <= '0;
                            r_state       <= RUN;
                            r_running     <= 1'b1;
                            r_cycle_count <= '0;
                        end else begin
                            r_sys_reset[0] <= 1'b0;
                            r_state        <= RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                RELEASE: begin
                    r_cnt       <= r_cnt + 32'd1;
                    r_sys_reset <= r_sys_reset & w_keep;
                    if ((r_cnt + 32'd1) == 32'(LAST)) begin
                        r_state       <= RUN;
                        r_running     <= 1'b1;
                        r_cycle_count <= '0;
                    end
                end
                RUN: begin
                    // halt takes priority over a coincident timeout
                    if (bus.halt) begin
                        r_state     <= DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_sys_reset <= '1;
                    end else if (MAX_CYCLES != 0 && r_cycle_count == MAX_M1) begin
                        r_state       <= DONE;
                        r_running     <= 1'b0;
                        r_done        <= 1'b1;
                        r_timeout     <= 1'b1;
                        r_sys_reset   <= '1;
                        r_cycle_count <= MAX_V;
                    end else if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        r_state       <= HOLD;
                        r_cnt         <= '0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.sys_reset   = r_sys_reset;
    assign bus.running     = r_running;
    assign bus.done        = r_done;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed table-driven bench for run_sequencer (default and variant builds)
module tb_run_sequencer;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    run_sequencer_if #(.N_RST(2), .CNT_W(32)) ifa ();
    run_sequencer_if #(.N_RST(3), .CNT_W(32)) ifb ();
    run_sequencer #(
        .N_RST(2), .HOLD_CYCLES(4), .STAGGER(2), .MAX_CYCLES(500), .CNT_W(32), .AUTO_START(1)
    ) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    run_sequencer #(
        .N_RST(3), .HOLD_CYCLES(4), .STAGGER(0), .MAX_CYCLES(0), .CNT_W(32), .AUTO_START(0)
    ) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));
    typedef struct {
        int         e;
        logic       rst;
        logic       st;
        logic       hl;
        logic [1:0] sys;
        logic       run;
        logic       dn;
        logic       to;
        int         cnt;
    } vec_t;
    vec_t v[$];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic check_a(input int e, input logic [1:0] sys, input logic run, input logic dn,
                           input logic to, input int cnt);
        check($sformatf("A E%0d sys_reset", e), 64'(ifa.sys_reset), 64'(sys));
        check($sformatf("A E%0d running", e), 64'(ifa.running), 64'(run));
        check($sformatf("A E%0d done", e), 64'(ifa.done), 64'(dn));
        check($sformatf("A E%0d timeout", e), 64'(ifa.timeout), 64'(to));
        check($sformatf("A E%0d cycle_count", e), 64'(ifa.cycle_count), 64'(cnt));
    endtask
    initial begin
        int cur;
        ifa.start = 1'b0;
        ifa.halt  = 1'b0;
        ifb.start = 1'b0;
        ifb.halt  = 1'b0;
        //            e    rst  st   hl   sys    run  dn   to   cnt
        v.push_back('{1,    0,   0,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{4,    0,   0,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{5,    0,   0,   0,   2'b10, 0,   0,   0,   0});
        v.push_back('{6,    0,   0,   0,   2'b10, 0,   0,   0,   0});
        v.push_back('{7,    0,   0,   0,   2'b00, 1,   0,   0,   0});
        v.push_back('{8,    0,   0,   0,   2'b00, 1,   0,   0,   1});
        v.push_back('{50,   0,   1,   0,   2'b00, 1,   0,   0,   43});
        v.push_back('{51,   0,   0,   0,   2'b00, 1,   0,   0,   44});
        v.push_back('{506,  0,   0,   0,   2'b00, 1,   0,   0,   499});
        v.push_back('{507,  0,   0,   0,   2'b11, 0,   1,   1,   500});
        v.push_back('{530,  0,   0,   1,   2'b11, 0,   1,   1,   500});
        v.push_back('{557,  0,   0,   0,   2'b11, 0,   1,   1,   500});
        v.push_back('{600,  0,   1,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{603,  0,   0,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{604,  0,   0,   0,   2'b10, 0,   0,   0,   0});
        v.push_back('{605,  0,   0,   0,   2'b10, 0,   0,   0,   0});
        v.push_back('{606,  0,   0,   0,   2'b00, 1,   0,   0,   0});
        v.push_back('{607,  0,   0,   0,   2'b00, 1,   0,   0,   1});
        v.push_back('{706,  0,   0,   0,   2'b00, 1,   0,   0,   100});
        v.push_back('{707,  0,   0,   1,   2'b11, 0,   1,   0,   100});
        v.push_back('{720,  0,   0,   0,   2'b11, 0,   1,   0,   100});
        v.push_back('{730,  0,   1,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{736,  0,   0,   0,   2'b00, 1,   0,   0,   0});
        v.push_back('{1235, 0,   0,   0,   2'b00, 1,   0,   0,   499});
        v.push_back('{1236, 0,   0,   1,   2'b11, 0,   1,   0,   499});
        v.push_back('{1250, 0,   1,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{1256, 0,   0,   0,   2'b00, 1,   0,   0,   0});
        v.push_back('{1300, 1,   0,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{1301, 0,   0,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{1304, 0,   0,   0,   2'b11, 0,   0,   0,   0});
        v.push_back('{1305, 0,   0,   0,   2'b10, 0,   0,   0,   0});
        v.push_back('{1307, 0,   0,   0,   2'b00, 1,   0,   0,   0});
        v.push_back('{1308, 0,   0,   0,   2'b00, 1,   0,   0,   1});
        #1;
        repeat (3) tick();
        check_a(0, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        check("B reset sys_reset", 64'(ifb.sys_reset), 64'(3'b111));
        rst_a = 1'b0;
        rst_b = 1'b0;
        cur = 0;
        foreach (v[k]) begin
            while (cur < v[k].e - 1) begin
                tick();
                cur++;
            end
            rst_a     = v[k].rst;
            ifa.start = v[k].st;
            ifa.halt  = v[k].hl;
            tick();
            cur++;
            rst_a     = 1'b0;
            ifa.start = 1'b0;
            ifa.halt  = 1'b0;
            check_a(v[k].e, v[k].sys, v[k].run, v[k].dn, v[k].to, v[k].cnt);
        end
        check("B idle sys_reset", 64'(ifb.sys_reset), 64'(3'b111));
        check("B idle running", 64'(ifb.running), 64'd0);
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        check("B Es sys_reset", 64'(ifb.sys_reset), 64'(3'b111));
        check("B Es running", 64'(ifb.running), 64'd0);
        repeat (3) tick();
        check("B Es+3 sys_reset", 64'(ifb.sys_reset), 64'(3'b111));
        tick();
        check("B Es+4 sys_reset", 64'(ifb.sys_reset), 64'(3'b000));
        check("B Es+4 running", 64'(ifb.running), 64'd1);
        check("B Es+4 cycle_count", 64'(ifb.cycle_count), 64'd0);
        repeat (1100) tick();
        check("B long cycle_count", 64'(ifb.cycle_count), 64'd1100);
        check("B long running", 64'(ifb.running), 64'd1);
        check("B long timeout", 64'(ifb.timeout), 64'd0);
        check("B long done", 64'(ifb.done), 64'd0);
        ifb.halt = 1'b1;
        tick();
        ifb.halt = 1'b0;
        check("B halt done", 64'(ifb.done), 64'd1);
        check("B halt timeout", 64'(ifb.timeout), 64'd0);
        check("B halt cycle_count", 64'(ifb.cycle_count), 64'd1100);
        check("B halt sys_reset", 64'(ifb.sys_reset), 64'(3'b111));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
